// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
// The arbiter connects through the slave modport, the requesting side through master.
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] breq;
    logic                   s_ready;
    logic [NUM_MASTERS-1:0] bgrant;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   bus_busy;
    logic                   timeout;

    modport slave (
        input  breq,
        input  s_ready,
        output bgrant,
        output gnt_idx,
        output bus_busy,
        output timeout
    );

    modport master (
        output breq,
        output s_ready,
        input  bgrant,
        input  gnt_idx,
        input  bus_busy,
        input  timeout
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus: one grantee at a time, one dead
// cycle between grants, new grants gated by s_ready, optional hold-time limit.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int HOLD_MAX    = 64,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_rr_if.slave  bus
);
    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                 state_q,    state_d;
    logic [NUM_MASTERS-1:0] bgrant_q,   bgrant_d;
    logic [IDX_W-1:0]       gnt_idx_q,  gnt_idx_d;
    logic                   bus_busy_q, bus_busy_d;
    logic                   timeout_q,  timeout_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [IDX_W-1:0]       last_q,     last_d;

    logic                   eligible_s;
    logic                   win_found_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [IDX_W-1:0]       cand_s;
    logic                   hold_expired_s;

    // Winner search: first requester strictly after the last grantee, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand_s = IDX_W'((int'(last_q) + off) % NUM_MASTERS);
            if (!win_found_s && bus.breq[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        eligible_s = win_found_s && bus.s_ready;
    end

    // Hold limit reached; a limit of zero never expires.
    always_comb begin
        if (HOLD_MAX != 0) begin
            hold_expired_s = (cnt_q == CNT_W'(HOLD_MAX));
        end else begin
            hold_expired_s = 1'b0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        bgrant_d  = bgrant_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;

        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                if (eligible_s) begin
                    state_d   = ST_GRANT;
                    bgrant_d  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx_s;
                    gnt_idx_d = win_idx_s;
                    last_d    = win_idx_s;
                    cnt_d     = CNT_W'(1);
                end else begin
                    state_d   = ST_IDLE;
                    bgrant_d  = '0;
                end
            end
            ST_GRANT: begin
                // A dropped request takes precedence over an expiring hold.
                if (!bus.breq[gnt_idx_q]) begin
                    state_d  = ST_RELEASE;
                    bgrant_d = '0;
                end else if (hold_expired_s) begin
                    state_d   = ST_RELEASE;
                    bgrant_d  = '0;
                    timeout_d = 1'b1;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bgrant_d = '0;
            end
        endcase

        bus_busy_d = |bgrant_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bgrant_q   <= '0;
            gnt_idx_q  <= '0;
            bus_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            last_q     <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q    <= state_d;
            bgrant_q   <= bgrant_d;
            gnt_idx_q  <= gnt_idx_d;
            bus_busy_q <= bus_busy_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    assign bus.bgrant   = bgrant_q;
    assign bus.gnt_idx  = gnt_idx_q;
    assign bus.bus_busy = bus_busy_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized and directed bench for bus_arbiter_rr against an ownership-level model
// that tracks who owns the bus, for how long, and who was served last.
module tb_bus_arbiter_rr;
    localparam int N  = 2;
    localparam int HM = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter_rr_if #(.NUM_MASTERS(N)) bif ();

    bus_arbiter_rr #(.NUM_MASTERS(N), .HOLD_MAX(HM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_chk = 0;
    int n_bad = 0;

    // model: owner of the bus (-1 = nobody), cycles owned, last served, index output
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = N - 1;
    int m_gidx  = 0;
    bit m_to    = 1'b0;

    int hold_len [N];
    int fixed_len   = 0;
    int rereq_pct   = 0;
    int to_seen     = 0;
    int obs_q [$];
    logic [N-1:0] prev_gnt = '0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = N - 1; m_gidx = 0;
        end else if (m_owner >= 0) begin
            if (!bif.breq[m_owner]) begin
                m_owner = -1;
            end else if (m_held == HM) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            w = pick_winner(bif.breq);
            if (w >= 0 && bif.s_ready) begin
                m_owner = w; m_gidx = w; m_last = w; m_held = 1;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_g;
        @(posedge clk);
        model_edge();
        #1;
        exp_g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk_eq("bgrant",   32'(bif.bgrant),   32'(exp_g));
        chk_eq("gnt_idx",  32'(bif.gnt_idx),  32'(m_gidx));
        chk_eq("bus_busy", 32'(bif.bus_busy), 32'(m_owner >= 0));
        chk_eq("timeout",  32'(bif.timeout),  32'(m_to));
        if (bif.timeout) to_seen++;
        if (bif.bgrant != '0 && prev_gnt == '0) obs_q.push_back(int'(bif.gnt_idx));
        prev_gnt = bif.bgrant;
    endtask

    // masters that hold a granted request for hold_len cycles, then maybe re-request
    task automatic cycle_agents();
        step();
        for (int i = 0; i < N; i++) begin
            if (m_owner == i) begin
                if (m_held == 1)
                    hold_len[i] = (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 12));
                if (m_held >= hold_len[i]) bif.breq[i] = 1'b0;
            end else if (!bif.breq[i] && ($urandom_range(0, 99) < rereq_pct)) begin
                bif.breq[i] = 1'b1;
            end
        end
    endtask

    initial begin
        int max0, run0, guard;
        for (int i = 0; i < N; i++) hold_len[i] = 1;
        rst = 1'b1; bif.breq = '0; bif.s_ready = 1'b1;
        #2;
        step(); step();
        rst = 1'b0;
        step();

        // single request
        bif.breq = 2'b01;
        step();
        chk_eq("single_gnt", 32'(bif.bgrant), 32'h1);
        for (int i = 0; i < 9; i++) step();
        bif.breq = 2'b00;
        step();
        chk_eq("single_rel", 32'(bif.bgrant), 32'h0);
        chk_eq("single_busy", 32'(bif.bus_busy), 32'h0);
        step(); step();

        // simultaneous requests from reset: m0 then m1
        rst = 1'b1; step(); rst = 1'b0;
        obs_q.delete();
        fixed_len = 6; rereq_pct = 0;
        bif.breq = 2'b11;
        for (int i = 0; i < 20; i++) cycle_agents();
        chk_eq("simul_n", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            chk_eq("simul_first", 32'(obs_q[0]), 32'd0);
            chk_eq("simul_second", 32'(obs_q[1]), 32'd1);
        end

        // fairness: immediate re-requests must alternate grantees
        obs_q.delete();
        fixed_len = 0; rereq_pct = 100;
        bif.breq = 2'b11;
        guard = 0;
        while (obs_q.size() < 21 && guard < 600) begin
            cycle_agents();
            guard++;
        end
        chk_eq("fair_count", 32'(obs_q.size() >= 21), 32'd1);
        for (int i = 1; i < obs_q.size(); i++)
            chk_eq("fair_alt", 32'(obs_q[i] != obs_q[i-1]), 32'd1);
        bif.breq = '0;
        step(); step(); step();

        // slave-ready gating
        bif.s_ready = 1'b0; bif.breq = 2'b10;
        for (int i = 0; i < 15; i++) step();
        chk_eq("gate_hold", 32'(bif.bgrant), 32'h0);
        bif.s_ready = 1'b1;
        step();
        chk_eq("gate_open", 32'(bif.bgrant), 32'h2);
        bif.s_ready = 1'b0;
        step(); step(); step();
        chk_eq("gate_mid", 32'(bif.bgrant), 32'h2);
        bif.s_ready = 1'b1; bif.breq = '0;
        step(); step();

        // timeout with competing master: m0 wins first (m1 served last)
        bif.breq = 2'b11;
        to_seen = 0; max0 = 0; run0 = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bif.bgrant[0]) run0++;
            else begin
                if (run0 > max0) max0 = run0;
                run0 = 0;
            end
            if (i == 8) begin
                chk_eq("to_pulse", 32'(bif.timeout), 32'd1);
                chk_eq("to_idx", 32'(bif.gnt_idx), 32'd0);
            end
            if (i == 9) chk_eq("to_next", 32'(bif.bgrant), 32'h2);
        end
        chk_eq("to_maxrun", 32'(max0), 32'(HM));
        bif.breq = '0;
        step(); step(); step();

        // timeout with m0 alone: re-granted after one dead cycle
        to_seen = 0;
        bif.breq = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 9) chk_eq("solo_regrant", 32'(bif.bgrant), 32'h1);
        end
        chk_eq("solo_to_cnt", 32'(to_seen), 32'd2);
        bif.breq = '0;
        step(); step();

        // reset during a grant to m1
        bif.breq = 2'b10;
        step(); step(); step();
        chk_eq("rg_pre", 32'(bif.bgrant), 32'h2);
        rst = 1'b1;
        step();
        chk_eq("rg_gnt", 32'(bif.bgrant), 32'h0);
        chk_eq("rg_idx", 32'(bif.gnt_idx), 32'h0);
        chk_eq("rg_to", 32'(bif.timeout), 32'h0);
        rst = 1'b0; bif.breq = 2'b11;
        step();
        chk_eq("rg_first", 32'(bif.bgrant), 32'h1);
        bif.breq = '0;
        step(); step();

        // random traffic with random slave readiness
        fixed_len = 0; rereq_pct = 30;
        for (int i = 0; i < 800; i++) begin
            bif.s_ready = ($urandom_range(0, 3) != 0);
            cycle_agents();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin bus arbiter for the serial system bus, sitting between the master ports' `mbreq`/`mbgrant` pair and the address/data mux of the bus interconnect. It grants the shared bus to one master at a time and holds the grant until that master drops its request. It gates new grants on the slave-ready indication and enforces a maximum hold time. It exposes the granted index so the interconnect can steer `mwdata`/`mmode`/`mvalid` to the slave and return `srdata`/`svalid`.

## Interface
- `NUM_MASTERS`, default 2: number of requesters, range 2..8.
- `HOLD_MAX`, default 64: maximum consecutive grant cycles; 0 disables the timeout.
- `IDX_W`, default `$clog2(NUM_MASTERS)`: width of the index outputs.

- `clk`  in  1  bus clock.
- `rst`  in  1  reset: one clock domain; reset is synchronous and active-high.
- `breq`  in  NUM_MASTERS  per-master bus request, level, held for the whole transaction.
- `s_ready`  in  1  slave idle; a new grant is issued only while high.
- `bgrant`  out  NUM_MASTERS  one-hot or zero grant, registered.
- `gnt_idx`  out  IDX_W  index of the current or most recent grantee; mux select.
- `bus_busy`  out  1  high while any `bgrant` bit is high.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly withdrawn.

## Operation
- States: IDLE, GRANT, RELEASE.
- Reset values: state IDLE, `bgrant`=0, `gnt_idx`=0, `bus_busy`=0, `timeout`=0, hold counter 0, round-robin pointer `last`=NUM_MASTERS-1, so master 0 has first priority.
- **Eligible:** there is at least one `breq` bit set and `s_ready`=1.
- **Winner selection:** the first set `breq` bit searching upward from `last`+1, modulo NUM_MASTERS.
- **IDLE:**
  - If eligible, go to GRANT: set `bgrant[winner]`, `gnt_idx`=winner, `last`=winner, counter=1.
  - Otherwise stay in IDLE.
- **GRANT, normal release:** if `breq[gnt_idx]`=0, go to RELEASE with `bgrant`=0.
- **GRANT, timeout:** if HOLD_MAX≠0, counter==HOLD_MAX and `breq[gnt_idx]`=1, go to RELEASE with `bgrant`=0 and `timeout`=1 for exactly that RELEASE cycle.
  - If both the normal-release and timeout conditions hold in the same cycle, normal release wins and `timeout` stays 0.
- **GRANT, otherwise:** hold the grant and increment the counter. The counter saturates and never wraps.
- **RELEASE:** a single mandatory dead cycle.
  - If eligible, go to GRANT with a fresh winner and counter=1.
  - Otherwise go to IDLE.
  - `gnt_idx` keeps the previous grantee throughout RELEASE and IDLE.
- **Timed-out master:** it is already last in priority because `last` equals its index. If it is the sole requester it is re-granted after the dead cycle.
- **`s_ready` during GRANT:** ignored; it only gates new grants.
- **Request pulses:** a `breq` bit that rises and falls while another master is granted is never seen. Masters must hold `breq` until granted.
- **Reset while in GRANT:** `bgrant` returns to 0 on the first clock edge at which `rst`=1. No `timeout` pulse is generated. The round-robin pointer is reset.

## Timing
- Request-to-grant latency from IDLE: `breq` is sampled high at edge N and `bgrant` is high after edge N. A requester asserting between edges N-1 and N sees its grant one cycle later.
- Grant withdrawal: `breq` is sampled low at edge K, `bgrant` goes to 0 after edge K, and the next grant can be high after edge K+1 at the earliest. Back-to-back transfers therefore always have exactly one idle bus cycle between grants.
- With timeout, `bgrant` stays high for at most HOLD_MAX consecutive cycles.
- `bus_busy` equals the OR of `bgrant` in the same cycle; it is registered, not combinational.
- All outputs are glitch-free registers. There is no combinational path from `breq` or `s_ready` to any output.

## Test plan
- **Single request:** with `rst` low and `s_ready`=1, raise `breq`=01 → `bgrant`=01 one cycle later and `gnt_idx`=0. Drop `breq` after 10 cycles → `bgrant`=00 on the next edge, and `bus_busy` follows.
- **Simultaneous requests from reset:** raise `breq`=11 on the same edge, with each master dropping 6 cycles after its own grant → m0 granted first, one dead cycle, then m1 granted with `gnt_idx`=1.
- **Fairness:** both masters re-request immediately after every release for 20 transactions → grants strictly alternate 0,1,0,1,… with no repeated grantee.
- **Slave-ready gating:** hold `s_ready`=0 with `breq`=10 for 15 cycles → `bgrant` stays 00. Raise `s_ready` → `bgrant`=10 one cycle later. Drop `s_ready` mid-grant → grant is held.
- **Timeout:** with HOLD_MAX=8, m0 holds `breq` for 30 cycles while m1 requests → `bgrant[0]` is high for exactly 8 cycles, `timeout` pulses for 1 cycle with `gnt_idx`=0, then `bgrant`=10. Repeat with m0 alone → m0 is re-granted after one dead cycle.
- **Reset mid-grant:** assert `rst` for 1 cycle during a grant to m1 → all outputs reach reset values on that edge and `timeout` stays 0. Then raise `breq`=11 → m0 is granted first.
